// File: rtl/romulator_pkg.sv
// Shared definitions for the romulator capture stages: controller states,
// default video window geometry and the window-hit helper.
package romulator_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } cap_state_e;

    localparam logic [15:0] VRAM_BASE_DEF = 16'h8000;
    localparam int          SIZE_40_DEF   = 1000;
    localparam int          SIZE_80_DEF   = 2000;

    // 17-bit compare so a window near FFFF never wraps back to low memory
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [16:0] size);
        logic [16:0] a_s;
        logic [16:0] lo_s;
        a_s  = {1'b0, addr};
        lo_s = {1'b0, base};
        return (a_s >= lo_s) && (a_s < (lo_s + size));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with flush; a push while full is accepted only
// when a pop or flush frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             fpga_clk,
    input  logic             fpga_reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_push_s = push & (~full | pop | flush);
    assign do_pop_s  = pop & ~empty & ~flush;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= do_push_s ? AW'(1) : '0;
            count_r  <= do_push_s ? (AW+1)'(1) : '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage; a push during flush lands in slot 0 as the new head
    always_ff @(posedge fpga_clk) begin
        if (do_push_s) mem_r[flush ? '0 : wr_ptr_r] <= din;
    end

endmodule

// File: rtl/vram_capture.sv
// Snoops CPU writes into the video window, queues them and replays them into
// the video RAM write port; also runs a whole-window zero-fill engine.
module vram_capture
    import romulator_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE  = VRAM_BASE_DEF,
    parameter int          VRAM_AW    = 11,
    parameter int          FIFO_DEPTH = 4,
    parameter int          SIZE_40    = SIZE_40_DEF,
    parameter int          SIZE_80    = SIZE_80_DEF
) (
    input  logic               fpga_clk,
    input  logic               fpga_reset,
    input  logic               cpu_phi2,
    input  logic [15:0]        cpu_address,
    input  logic [7:0]         cpu_data,
    input  logic               cpu_rwb,
    input  logic               halt,
    input  logic               cols80,
    input  logic               clear_request,
    output logic [VRAM_AW-1:0] vram_write_address,
    output logic [7:0]         vram_write_data,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_size,
    output logic               clear_busy,
    output logic               overflow,
    output logic [15:0]        capture_count
);
    localparam int EW = VRAM_AW + 8;

    logic               s1_r, s2_r, s3_r;
    logic [15:0]        addr_lat_r;
    logic [7:0]         data_lat_r;
    logic               rwb_lat_r;
    cap_state_e         state_r, state_n_s;
    logic [VRAM_AW-1:0] clr_ptr_r;
    logic [VRAM_AW-1:0] vram_size_r;
    logic               overflow_r;
    logic [15:0]        capture_count_r;
    logic [VRAM_AW-1:0] wr_addr_r;
    logic [7:0]         wr_data_r;
    logic               we_r;

    logic               fall_s, qualify_s, accept_s, drop_s;
    logic [15:0]        diff_s;
    logic [EW-1:0]      fifo_din_s, fifo_dout_s;
    logic               fifo_full_s, fifo_empty_s;
    logic               pop_s, flush_s;

    // phi2 synchroniser plus history flop for fall detection
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= cpu_phi2;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Bus is sampled while synchronised phi2 is high; the last sample wins
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            addr_lat_r <= 16'h0000;
            data_lat_r <= 8'h00;
            rwb_lat_r  <= 1'b1;
        end else if (s2_r) begin
            addr_lat_r <= cpu_address;
            data_lat_r <= cpu_data;
            rwb_lat_r  <= cpu_rwb;
        end
    end

    assign fall_s     = s3_r & ~s2_r;
    assign qualify_s  = fall_s & ~rwb_lat_r & ~halt
                      & in_window(addr_lat_r, VRAM_BASE, 17'(vram_size_r));
    assign diff_s     = addr_lat_r - VRAM_BASE;
    assign fifo_din_s = {diff_s[VRAM_AW-1:0], data_lat_r};
    assign accept_s   = qualify_s & (~fifo_full_s | pop_s | flush_s);
    assign drop_s     = qualify_s & ~accept_s;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .fpga_clk   (fpga_clk),
        .fpga_reset (fpga_reset),
        .push       (qualify_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .din        (fifo_din_s),
        .dout       (fifo_dout_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Controller state register
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) state_r <= ST_IDLE;
        else            state_r <= state_n_s;
    end

    // Next state and FIFO control; a clear request beats a pop
    always_comb begin
        state_n_s = state_r;
        pop_s     = 1'b0;
        flush_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_request) begin
                    flush_s   = 1'b1;
                    state_n_s = ST_CLEAR;
                end else if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (clr_ptr_r == vram_size_r) state_n_s = ST_IDLE;
                else                          state_n_s = ST_CLEAR;
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Write port: the zero at address 0 is issued with the request so the
    // zero-write strobes line up exactly with clear_busy
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            we_r      <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
            clr_ptr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_request) begin
                        we_r      <= 1'b1;
                        wr_addr_r <= '0;
                        wr_data_r <= 8'h00;
                        clr_ptr_r <= VRAM_AW'(1);
                    end else if (!fifo_empty_s) begin
                        we_r      <= 1'b1;
                        wr_addr_r <= fifo_dout_s[EW-1:8];
                        wr_data_r <= fifo_dout_s[7:0];
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr_r == vram_size_r) begin
                        we_r <= 1'b0;
                    end else begin
                        we_r      <= 1'b1;
                        wr_addr_r <= clr_ptr_r;
                        wr_data_r <= 8'h00;
                        clr_ptr_r <= clr_ptr_r + VRAM_AW'(1);
                    end
                end
                default: we_r <= 1'b0;
            endcase
        end
    end

    // Window size tracks cols80 only while idle so a clear sees a fixed size
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset)              vram_size_r <= VRAM_AW'(SIZE_40);
        else if (state_r == ST_IDLE) vram_size_r <= cols80 ? VRAM_AW'(SIZE_80) : VRAM_AW'(SIZE_40);
    end

    // Sticky overflow and accepted-capture counter
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            overflow_r      <= 1'b0;
            capture_count_r <= 16'h0000;
        end else begin
            if (state_r == ST_IDLE && clear_request) overflow_r <= 1'b0;
            else if (drop_s)                         overflow_r <= 1'b1;
            if (accept_s) capture_count_r <= capture_count_r + 16'h0001;
        end
    end

    assign vram_write_address = wr_addr_r;
    assign vram_write_data    = wr_data_r;
    assign vram_we            = we_r;
    assign vram_size          = vram_size_r;
    assign clear_busy         = (state_r == ST_CLEAR);
    assign overflow           = overflow_r;
    assign capture_count      = capture_count_r;

endmodule

// File: tb/tb_vram_capture.sv
// Directed bench for vram_capture: capture path, window limits, clear engine,
// overflow and asynchronous reset.
module tb_vram_capture;

    logic        fpga_clk;
    logic        fpga_reset;
    logic        cpu_phi2;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_rwb;
    logic        halt;
    logic        cols80;
    logic        clear_request;
    logic [10:0] vram_write_address;
    logic [7:0]  vram_write_data;
    logic        vram_we;
    logic [10:0] vram_size;
    logic        clear_busy;
    logic        overflow;
    logic [15:0] capture_count;

    int checks = 0;
    int errors = 0;
    logic [18:0] log_q [$];
    int busy_cnt = 0;

    vram_capture dut (
        .fpga_clk           (fpga_clk),
        .fpga_reset         (fpga_reset),
        .cpu_phi2           (cpu_phi2),
        .cpu_address        (cpu_address),
        .cpu_data           (cpu_data),
        .cpu_rwb            (cpu_rwb),
        .halt               (halt),
        .cols80             (cols80),
        .clear_request      (clear_request),
        .vram_write_address (vram_write_address),
        .vram_write_data    (vram_write_data),
        .vram_we            (vram_we),
        .vram_size          (vram_size),
        .clear_busy         (clear_busy),
        .overflow           (overflow),
        .capture_count      (capture_count)
    );

    initial begin
        fpga_clk = 1'b0;
        forever #5 fpga_clk = ~fpga_clk;
    end

    // Record every write-port strobe and count busy cycles
    always @(negedge fpga_clk) begin
        if (vram_we)    log_q.push_back({vram_write_address, vram_write_data});
        if (clear_busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_high(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge fpga_clk);
        cpu_address = a;
        cpu_data    = d;
        cpu_rwb     = rw;
        cpu_phi2    = 1'b1;
        repeat (4) @(negedge fpga_clk);
    endtask

    task automatic cpu_access(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_high(a, d, rw);
        cpu_phi2 = 1'b0;
        repeat (5) @(negedge fpga_clk);
        cpu_rwb = 1'b1;
    endtask

    task automatic pulse_clear();
        @(negedge fpga_clk);
        clear_request = 1'b1;
        @(negedge fpga_clk);
        clear_request = 1'b0;
    endtask

    task automatic wait_clear_done();
        int n = 0;
        while (clear_busy && n < 3000) begin
            @(negedge fpga_clk);
            n++;
        end
        check("clear_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int bad;
        fpga_reset = 1'b1; cpu_phi2 = 1'b0; cpu_address = 16'h0000; cpu_data = 8'h00;
        cpu_rwb = 1'b1; halt = 1'b0; cols80 = 1'b0; clear_request = 1'b0;
        repeat (3) @(negedge fpga_clk);
        check("rst_we", 32'(vram_we), 32'd0);
        check("rst_size", 32'(vram_size), 32'd1000);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(capture_count), 32'd0);
        fpga_reset = 1'b0;
        repeat (2) @(negedge fpga_clk);

        // Single capture with exact latency from the phi2 fall
        log_q.delete();
        cpu_high(16'h8005, 8'h41, 1'b0);
        cpu_phi2 = 1'b0;
        repeat (3) @(posedge fpga_clk);
        #1 check("t1_we_early", 32'(vram_we), 32'd0);
        @(posedge fpga_clk);
        #1 check("t1_we", 32'(vram_we), 32'd1);
        check("t1_addr", 32'(vram_write_address), 32'h005);
        check("t1_data", 32'(vram_write_data), 32'h41);
        @(posedge fpga_clk);
        #1 check("t1_we_pulse", 32'(vram_we), 32'd0);
        repeat (3) @(negedge fpga_clk);
        cpu_rwb = 1'b1;
        check("t1_count", 32'(capture_count), 32'd1);
        check("t1_log", 32'(log_q.size()), 32'd1);

        // Window edges and reads in 40-column mode
        log_q.delete();
        cpu_access(16'h7FFF, 8'h11, 1'b0);
        cpu_access(16'h83E8, 8'h22, 1'b0);
        cpu_access(16'h8000, 8'h33, 1'b1);
        check("t2_none", 32'(log_q.size()), 32'd0);
        check("t2_count", 32'(capture_count), 32'd1);

        // 80-column window: 83E8 now inside, 87CF last byte, 87D0 outside
        cols80 = 1'b1;
        repeat (2) @(negedge fpga_clk);
        check("t3_size", 32'(vram_size), 32'd2000);
        log_q.delete();
        cpu_access(16'h83E8, 8'h5A, 1'b0);
        cpu_access(16'h87CF, 8'hC3, 1'b0);
        cpu_access(16'h87D0, 8'h77, 1'b0);
        check("t3_log", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) begin
            check("t3_e0", 32'(log_q[0]), 32'({11'h3E8, 8'h5A}));
            check("t3_e1", 32'(log_q[1]), 32'({11'h7CF, 8'hC3}));
        end
        check("t3_count", 32'(capture_count), 32'd3);

        // Halted CPU is ignored
        log_q.delete();
        halt = 1'b1;
        cpu_access(16'h8001, 8'h99, 1'b0);
        halt = 1'b0;
        check("t4_none", 32'(log_q.size()), 32'd0);
        check("t4_count", 32'(capture_count), 32'd3);

        // Clear with a capture landing mid-clear
        log_q.delete();
        busy_cnt = 0;
        @(negedge fpga_clk);
        clear_request = 1'b1;
        @(posedge fpga_clk);
        #1 check("t5_busy", 32'(clear_busy), 32'd1);
        check("t5_we0", 32'(vram_we), 32'd1);
        check("t5_addr0", 32'(vram_write_address), 32'd0);
        @(negedge fpga_clk);
        clear_request = 1'b0;
        repeat (50) @(negedge fpga_clk);
        cpu_access(16'h8010, 8'hAA, 1'b0);
        wait_clear_done();
        repeat (6) @(negedge fpga_clk);
        check("t5_busy_cycles", 32'(busy_cnt), 32'd2000);
        check("t5_log", 32'(log_q.size()), 32'd2001);
        bad = 0;
        for (int i = 0; i < 2000 && i < log_q.size(); i++)
            if (log_q[i] !== {11'(i), 8'h00}) bad++;
        check("t5_zero_seq", 32'(bad), 32'd0);
        if (log_q.size() >= 2001)
            check("t5_after", 32'(log_q[2000]), 32'({11'h010, 8'hAA}));
        check("t5_count", 32'(capture_count), 32'd4);

        // Six captures while the clear stalls the queue: four kept
        log_q.delete();
        pulse_clear();
        for (int i = 0; i < 6; i++)
            cpu_access(16'h8020 + 16'(i), 8'h10 + 8'(i), 1'b0);
        wait_clear_done();
        repeat (8) @(negedge fpga_clk);
        check("t6_ovf", 32'(overflow), 32'd1);
        check("t6_count", 32'(capture_count), 32'd8);
        check("t6_log", 32'(log_q.size()), 32'd2004);
        for (int i = 0; i < 4; i++)
            if (log_q.size() > 2000 + i)
                check("t6_entry", 32'(log_q[2000 + i]), 32'({11'h020 + 11'(i), 8'h10 + 8'(i)}));

        // Next clear drops overflow; reset mid-clear acts without a clock
        pulse_clear();
        check("t7_ovf_clr", 32'(overflow), 32'd0);
        check("t7_busy", 32'(clear_busy), 32'd1);
        repeat (20) @(negedge fpga_clk);
        #2 fpga_reset = 1'b1;
        #1;
        check("t7_rst_busy", 32'(clear_busy), 32'd0);
        check("t7_rst_we", 32'(vram_we), 32'd0);
        check("t7_rst_size", 32'(vram_size), 32'd1000);
        check("t7_rst_count", 32'(capture_count), 32'd0);
        repeat (2) @(negedge fpga_clk);
        fpga_reset = 1'b0;
        repeat (2) @(negedge fpga_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
